cruise_speed_ctrl: RTL and testbench

CRUISE_SPEED_CTRL -- requirements
Module: cruise_speed_ctrl

---
 rtl/cruise_speed_ctrl.sv | 146 ++++++++++++++
 tb/tb_cruise_speed_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cruise_speed_ctrl.sv
// rtl/cruise_speed_ctrl.sv - cruise control setpoint FSM with debounced speed correction
//
// Ports:
//   clk        - single clock, all state on rising edge
//   rst        - asynchronous active-high reset
//   power      - cruise master enable (level)
//   set        - capture current speed as setpoint / engage
//   resume     - re-engage at the retained setpoint
//   cancel     - drop to standby, keep setpoint
//   brake      - brake pedal, drop to standby, keep setpoint
//   speed      - current vehicle speed
//   in_g       - comparator: speed > set_speed
//   in_eq      - comparator: speed == set_speed
//   in_l       - comparator: speed < set_speed
//   set_speed  - registered setpoint feeding the comparator chain
//   accel      - registered request to add throttle
//   decel      - registered request to reduce throttle
//   cruising   - high iff the FSM is in CRUISE
//   err        - registered flag, one cycle per non-one-hot compare sample

module cruise_speed_ctrl #(
   parameter int WIDTH     = 8,
   parameter int HOLD      = 3,
   parameter int MIN_SPEED = 40
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             power,
   input  logic             set,
   input  logic             resume,
   input  logic             cancel,
   input  logic             brake,
   input  logic [WIDTH-1:0] speed,
   input  logic             in_g,
   input  logic             in_eq,
   input  logic             in_l,
   output logic [WIDTH-1:0] set_speed,
   output logic             accel,
   output logic             decel,
   output logic             cruising,
   output logic             err
);

   localparam int CW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

   typedef enum logic [1:0] {OFF, STANDBY, CRUISE} state_t;

   state_t           state, state_n;
   logic             set_valid, set_valid_n;
   logic [WIDTH-1:0] set_speed_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             last_g, last_g_n;
   logic             accel_n, decel_n, err_n;
   logic             fast_enough;
   logic             legal;
   logic             same_code;

   assign fast_enough = (speed >= WIDTH'(MIN_SPEED));
   assign legal       = ({in_g, in_eq, in_l} == 3'b100) ||
                        ({in_g, in_eq, in_l} == 3'b010) ||
                        ({in_g, in_eq, in_l} == 3'b001);
   // A nonzero count means the previous sample was a legal g/l code,
   // recorded in last_g.
   assign same_code   = (cnt != '0) && (last_g == in_g);

   always_comb begin
      state_n     = state;
      set_valid_n = set_valid;
      set_speed_n = set_speed;
      cnt_n       = '0;
      last_g_n    = last_g;
      accel_n     = 1'b0;
      decel_n     = 1'b0;
      err_n       = 1'b0;

      if (!power) begin
         state_n     = OFF;
         set_valid_n = 1'b0;
         set_speed_n = '0;
      end else begin
         case (state)
            OFF: state_n = STANDBY;
            STANDBY: begin
               if (brake || cancel) begin
                  state_n = STANDBY;
               end else if (set) begin
                  if (fast_enough) begin
                     state_n     = CRUISE;
                     set_speed_n = speed;
                     set_valid_n = 1'b1;
                  end
               end else if (resume && set_valid && fast_enough) begin
                  state_n = CRUISE;
               end
            end
            CRUISE: begin
               if (brake || cancel) begin
                  state_n = STANDBY;
               end else if (set && fast_enough) begin
                  // Recapture: counter and requests restart from zero.
                  set_speed_n = speed;
               end else begin
                  err_n = !legal;
                  if (legal && !in_eq) begin
                     if (!same_code)
                        cnt_n = CW'(1);
                     else if (cnt == CW'(HOLD))
                        cnt_n = cnt;
                     else
                        cnt_n = cnt + CW'(1);
                     last_g_n = in_g;
                     decel_n  = in_g && (cnt_n == CW'(HOLD));
                     accel_n  = in_l && (cnt_n == CW'(HOLD));
                  end
               end
            end
            default: state_n = OFF;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= OFF;
         set_valid <= 1'b0;
         set_speed <= '0;
         cnt       <= '0;
         last_g    <= 1'b0;
         accel     <= 1'b0;
         decel     <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         set_valid <= set_valid_n;
         set_speed <= set_speed_n;
         cnt       <= cnt_n;
         last_g    <= last_g_n;
         accel     <= accel_n;
         decel     <= decel_n;
         err       <= err_n;
      end
   end

   assign cruising = (state == CRUISE);

endmodule

// File: tb/tb_cruise_speed_ctrl.sv
// tb/tb_cruise_speed_ctrl.sv - table-driven bench for cruise_speed_ctrl

module tb_cruise_speed_ctrl;

   localparam logic [2:0] CG = 3'b100;
   localparam logic [2:0] CE = 3'b010;
   localparam logic [2:0] CL = 3'b001;
   localparam logic [2:0] CX = 3'b101;

   typedef struct {
      string      name;
      logic       power, set, resume, cancel, brake;
      logic [7:0] speed;
      logic [2:0] code;
      logic       cru;
      logic [7:0] ss;
      logic       acc, dec, er;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       power, set, resume, cancel, brake;
   logic [7:0] speed;
   logic       in_g, in_eq, in_l;
   logic [7:0] set_speed;
   logic       accel, decel, cruising, err;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   cruise_speed_ctrl #(.WIDTH(8), .HOLD(3), .MIN_SPEED(40)) dut (
      .clk(clk), .rst(rst), .power(power), .set(set), .resume(resume),
      .cancel(cancel), .brake(brake), .speed(speed),
      .in_g(in_g), .in_eq(in_eq), .in_l(in_l),
      .set_speed(set_speed), .accel(accel), .decel(decel),
      .cruising(cruising), .err(err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(string nm, logic pw, logic st, logic rs, logic cn, logic br,
                               logic [7:0] sp, logic [2:0] cd, logic cru, logic [7:0] ss,
                               logic acc, logic dec, logic er);
      vec_t v;
      v.name = nm; v.power = pw; v.set = st; v.resume = rs; v.cancel = cn; v.brake = br;
      v.speed = sp; v.code = cd; v.cru = cru; v.ss = ss; v.acc = acc; v.dec = dec; v.er = er;
      return v;
   endfunction

   task automatic check(string nm, int got, int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic check_all(string nm, logic cru, logic [7:0] ss, logic acc, logic dec, logic er);
      check({nm, ".cruising"}, int'(cruising), int'(cru));
      check({nm, ".set_speed"}, int'(set_speed), int'(ss));
      check({nm, ".accel"}, int'(accel), int'(acc));
      check({nm, ".decel"}, int'(decel), int'(dec));
      check({nm, ".err"}, int'(err), int'(er));
   endtask

   task automatic drive(logic pw, logic st, logic rs, logic cn, logic br, logic [7:0] sp, logic [2:0] cd);
      power = pw; set = st; resume = rs; cancel = cn; brake = br; speed = sp;
      {in_g, in_eq, in_l} = cd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //           name            pw st rs cn br spd  code cru ss  acc dec err
      vecs.push_back(mk("off_to_stby", 1, 1, 0, 0, 0, 60, CE, 0,  0, 0, 0, 0));
      vecs.push_back(mk("engage60",    1, 1, 0, 0, 0, 60, CE, 1, 60, 0, 0, 0));
      vecs.push_back(mk("eq_idle",     1, 0, 0, 0, 0, 60, CE, 1, 60, 0, 0, 0));
      vecs.push_back(mk("g1",          1, 0, 0, 0, 0, 60, CG, 1, 60, 0, 0, 0));
      vecs.push_back(mk("g2",          1, 0, 0, 0, 0, 60, CG, 1, 60, 0, 0, 0));
      vecs.push_back(mk("g3_decel",    1, 0, 0, 0, 0, 60, CG, 1, 60, 0, 1, 0));
      vecs.push_back(mk("g4_hold",     1, 0, 0, 0, 0, 60, CG, 1, 60, 0, 1, 0));
      vecs.push_back(mk("eq_drop",     1, 0, 0, 0, 0, 60, CE, 1, 60, 0, 0, 0));
      vecs.push_back(mk("seq_l1",      1, 0, 0, 0, 0, 60, CL, 1, 60, 0, 0, 0));
      vecs.push_back(mk("seq_l2",      1, 0, 0, 0, 0, 60, CL, 1, 60, 0, 0, 0));
      vecs.push_back(mk("seq_g1",      1, 0, 0, 0, 0, 60, CG, 1, 60, 0, 0, 0));
      vecs.push_back(mk("seq_g2",      1, 0, 0, 0, 0, 60, CG, 1, 60, 0, 0, 0));
      vecs.push_back(mk("seq_g3",      1, 0, 0, 0, 0, 60, CG, 1, 60, 0, 1, 0));
      vecs.push_back(mk("eq_clr",      1, 0, 0, 0, 0, 60, CE, 1, 60, 0, 0, 0));
      vecs.push_back(mk("l1",          1, 0, 0, 0, 0, 60, CL, 1, 60, 0, 0, 0));
      vecs.push_back(mk("l2",          1, 0, 0, 0, 0, 60, CL, 1, 60, 0, 0, 0));
      vecs.push_back(mk("l3_accel",    1, 0, 0, 0, 0, 60, CL, 1, 60, 1, 0, 0));
      vecs.push_back(mk("chg_drop",    1, 0, 0, 0, 0, 60, CG, 1, 60, 0, 0, 0));
      vecs.push_back(mk("illegal",     1, 0, 0, 0, 0, 60, CX, 1, 60, 0, 0, 1));
      vecs.push_back(mk("err_clear",   1, 0, 0, 0, 0, 60, CE, 1, 60, 0, 0, 0));
      vecs.push_back(mk("brk_cn_set",  1, 1, 0, 1, 1, 70, CE, 0, 60, 0, 0, 0));
      vecs.push_back(mk("resume50",    1, 0, 1, 0, 0, 50, CE, 1, 60, 0, 0, 0));
      vecs.push_back(mk("cancel",      1, 0, 0, 1, 0, 50, CE, 0, 60, 0, 0, 0));
      vecs.push_back(mk("set30_stby",  1, 1, 0, 0, 0, 30, CE, 0, 60, 0, 0, 0));
      vecs.push_back(mk("resume30",    1, 0, 1, 0, 0, 30, CE, 0, 60, 0, 0, 0));
      vecs.push_back(mk("set45",       1, 1, 0, 0, 0, 45, CE, 1, 45, 0, 0, 0));
      vecs.push_back(mk("reset80",     1, 1, 0, 0, 0, 80, CE, 1, 80, 0, 0, 0));
      vecs.push_back(mk("set20_cru",   1, 1, 0, 0, 0, 20, CE, 1, 80, 0, 0, 0));
      vecs.push_back(mk("power_off",   0, 0, 0, 0, 0, 60, CE, 0,  0, 0, 0, 0));
      vecs.push_back(mk("power_on",    1, 0, 0, 0, 0, 60, CE, 0,  0, 0, 0, 0));
      vecs.push_back(mk("resume_nov",  1, 0, 1, 0, 0, 60, CE, 0,  0, 0, 0, 0));

      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 8'd0, CE);
      step();
      step();
      check_all("reset", 0, 0, 0, 0, 0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].power, vecs[i].set, vecs[i].resume, vecs[i].cancel,
               vecs[i].brake, vecs[i].speed, vecs[i].code);
         step();
         check_all(vecs[i].name, vecs[i].cru, vecs[i].ss, vecs[i].acc, vecs[i].dec, vecs[i].er);
      end

      // Illegal code held two samples: err for each sample, requests stay low.
      drive(1, 1, 0, 0, 0, 8'd60, CE);
      step();
      check_all("reengage", 1, 60, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 8'd60, 3'b000);
      step();
      check_all("zero_code1", 1, 60, 0, 0, 1);
      step();
      check_all("zero_code2", 1, 60, 0, 0, 1);

      // Recapture in CRUISE drops an active request and restarts the count.
      drive(1, 0, 0, 0, 0, 8'd60, CG);
      step(); step(); step();
      check_all("pre_recap", 1, 60, 0, 1, 0);
      drive(1, 1, 0, 0, 0, 8'd65, CG);
      step();
      check_all("recap", 1, 65, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 8'd65, CG);
      step(); step();
      check_all("recap_g2", 1, 65, 0, 0, 0);
      step();
      check_all("recap_g3", 1, 65, 0, 1, 0);

      // Asynchronous reset mid-cycle while decel is active.
      #2;
      rst = 1'b1;
      #1;
      check_all("async_rst", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      drive(1, 0, 1, 0, 0, 8'd60, CE);
      step();
      check_all("post_rst_e1", 0, 0, 0, 0, 0);
      step();
      check_all("post_rst_resume", 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 8'd55, CE);
      step();
      check_all("post_rst_set", 1, 55, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (accel && decel) begin
            errors++;
            $display("FAIL excl: got accel=%0d decel=%0d expected not both 1", accel, decel);
         end
      end
   end

endmodule
